edac_err_log: RTL and testbench



---
 rtl/edac_log_pkg.sv | 19 +
 rtl/edac_log_fifo.sv | 53 +++++
 rtl/edac_err_log.sv | 103 ++++++++++
 tb/tb_edac_err_log.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/edac_log_pkg.sv
// Shared types and helpers for the EDAC error logger: entry type codes,
// entry width and the saturating counter increment.
package edac_log_pkg;

    localparam logic LOG_CORR   = 1'b0;
    localparam logic LOG_UNCORR = 1'b1;

    function automatic int entry_width(input int ram_logdepth);
        return ram_logdepth + 1;
    endfunction

    // Counters up to 32 bits wide; the caller casts in and out.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/edac_log_fifo.sv
// First-word-fall-through FIFO with flush; accepts a push while full when a pop
// happens in the same cycle, and reports pushes it had to drop.
module edac_log_fifo #(
    parameter int WIDTH    = 9,
    parameter int LOGDEPTH = 2
) (
    input  logic             clk,
    input  logic             nGrst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    localparam int DEPTH = 1 << LOGDEPTH;

    logic [LOGDEPTH:0]   wr_ptr, rd_ptr;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic                do_push, do_pop;
    logic [LOGDEPTH-1:0] wr_idx;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[LOGDEPTH] != rd_ptr[LOGDEPTH]) &&
                   (wr_ptr[LOGDEPTH-1:0] == rd_ptr[LOGDEPTH-1:0]);

    // A flush empties the FIFO first, so a push alongside it always lands.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (flush | ~full | do_pop);
    assign drop    = push & ~do_push;
    assign wr_idx  = flush ? '0 : wr_ptr[LOGDEPTH-1:0];
    assign dout    = mem[rd_ptr[LOGDEPTH-1:0]];

    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) mem[wr_idx] <= din;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= {{LOGDEPTH{1'b0}}, do_push};
            end else begin
                if (do_push) wr_ptr <= wr_ptr + (LOGDEPTH+1)'(1);
                if (do_pop)  rd_ptr <= rd_ptr + (LOGDEPTH+1)'(1);
            end
        end
    end

endmodule

// File: rtl/edac_err_log.sv
// EDAC error-event logger: saturating event counters, a FWFT log of failing
// addresses, a sticky overflow flag and a level interrupt for the host.
module edac_err_log
    import edac_log_pkg::*;
#(
    parameter int RAM_LOGDEPTH  = 8,
    parameter int CNT_WIDTH     = 16,
    parameter int FIFO_LOGDEPTH = 2,
    parameter int CORR_THRESH   = 8
) (
    input  logic                    clk,
    input  logic                    nGrst,
    input  logic                    correctable,
    input  logic                    error,
    input  logic [RAM_LOGDEPTH-1:0] err_addr,
    input  logic                    scrub_corr,
    input  logic                    scrub_done,
    input  logic                    clr,
    input  logic                    pop,
    output logic                    log_valid,
    output logic [RAM_LOGDEPTH-1:0] log_addr,
    output logic                    log_uncorr,
    output logic                    log_full,
    output logic                    overflow,
    output logic [CNT_WIDTH-1:0]    corr_cnt,
    output logic [CNT_WIDTH-1:0]    uncorr_cnt,
    output logic [CNT_WIDTH-1:0]    scrub_cnt,
    output logic [CNT_WIDTH-1:0]    pass_cnt,
    output logic                    irq
);
    localparam int ENTRY_W = entry_width(RAM_LOGDEPTH);

    logic                 event_v;
    logic                 fifo_empty, fifo_drop;
    logic [ENTRY_W-1:0]   entry_in, entry_out;
    logic [CNT_WIDTH-1:0] corr_nxt, uncorr_nxt, scrub_nxt, pass_nxt;
    logic [CNT_WIDTH-1:0] corr_base, uncorr_base, scrub_base, pass_base;
    logic                 overflow_nxt, irq_nxt;

    // Both flags together count as a single uncorrectable event.
    assign event_v  = correctable | error;
    assign entry_in = {(error ? LOG_UNCORR : LOG_CORR), err_addr};

    edac_log_fifo #(
        .WIDTH    (ENTRY_W),
        .LOGDEPTH (FIFO_LOGDEPTH)
    ) u_fifo (
        .clk   (clk),
        .nGrst (nGrst),
        .flush (clr),
        .push  (event_v),
        .pop   (pop),
        .din   (entry_in),
        .dout  (entry_out),
        .full  (log_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign log_valid  = ~fifo_empty;
    assign log_addr   = entry_out[RAM_LOGDEPTH-1:0];
    assign log_uncorr = entry_out[RAM_LOGDEPTH];

    always_comb begin
        corr_base   = clr ? '0 : corr_cnt;
        uncorr_base = clr ? '0 : uncorr_cnt;
        scrub_base  = clr ? '0 : scrub_cnt;
        pass_base   = clr ? '0 : pass_cnt;

        corr_nxt   = corr_base;
        uncorr_nxt = uncorr_base;
        scrub_nxt  = scrub_base;
        pass_nxt   = pass_base;

        if (correctable & ~error) corr_nxt   = CNT_WIDTH'(sat_inc(32'(corr_base),   CNT_WIDTH));
        if (error)                uncorr_nxt = CNT_WIDTH'(sat_inc(32'(uncorr_base), CNT_WIDTH));
        if (scrub_corr)           scrub_nxt  = CNT_WIDTH'(sat_inc(32'(scrub_base),  CNT_WIDTH));
        if (scrub_done)           pass_nxt   = CNT_WIDTH'(sat_inc(32'(pass_base),   CNT_WIDTH));

        overflow_nxt = (clr ? 1'b0 : overflow) | fifo_drop;
        irq_nxt      = (clr ? 1'b0 : irq) | (uncorr_nxt != '0) |
                       (32'(corr_nxt) >= 32'(CORR_THRESH)) | overflow_nxt;
    end

    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            scrub_cnt  <= '0;
            pass_cnt   <= '0;
            overflow   <= 1'b0;
            irq        <= 1'b0;
        end else begin
            corr_cnt   <= corr_nxt;
            uncorr_cnt <= uncorr_nxt;
            scrub_cnt  <= scrub_nxt;
            pass_cnt   <= pass_nxt;
            overflow   <= overflow_nxt;
            irq        <= irq_nxt;
        end
    end

endmodule

// File: tb/tb_edac_err_log.sv
// Directed bench for edac_err_log: default instance plus a 4-bit-counter
// instance sharing the same stimulus.
module tb_edac_err_log;
    logic       clk = 1'b0;
    logic       nGrst;
    logic       correctable, error, scrub_corr, scrub_done, clr, pop;
    logic [7:0] err_addr;

    logic        log_valid, log_uncorr, log_full, overflow, irq;
    logic [7:0]  log_addr;
    logic [15:0] corr_cnt, uncorr_cnt, scrub_cnt, pass_cnt;

    logic        log_valid4, log_uncorr4, log_full4, overflow4, irq4;
    logic [7:0]  log_addr4;
    logic [3:0]  corr_cnt4, uncorr_cnt4, scrub_cnt4, pass_cnt4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    edac_err_log dut (
        .clk(clk), .nGrst(nGrst), .correctable(correctable), .error(error),
        .err_addr(err_addr), .scrub_corr(scrub_corr), .scrub_done(scrub_done),
        .clr(clr), .pop(pop), .log_valid(log_valid), .log_addr(log_addr),
        .log_uncorr(log_uncorr), .log_full(log_full), .overflow(overflow),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .scrub_cnt(scrub_cnt),
        .pass_cnt(pass_cnt), .irq(irq)
    );

    edac_err_log #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .nGrst(nGrst), .correctable(correctable), .error(error),
        .err_addr(err_addr), .scrub_corr(scrub_corr), .scrub_done(scrub_done),
        .clr(clr), .pop(pop), .log_valid(log_valid4), .log_addr(log_addr4),
        .log_uncorr(log_uncorr4), .log_full(log_full4), .overflow(overflow4),
        .corr_cnt(corr_cnt4), .uncorr_cnt(uncorr_cnt4), .scrub_cnt(scrub_cnt4),
        .pass_cnt(pass_cnt4), .irq(irq4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        correctable = 0; error = 0; scrub_corr = 0; scrub_done = 0; clr = 0; pop = 0;
    endtask

    task automatic ev(input logic [7:0] a, input logic c, input logic e, input logic p);
        err_addr = a; correctable = c; error = e; pop = p;
        tick();
        idle();
    endtask

    task automatic do_clr();
        clr = 1;
        tick();
        idle();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_corr"},   32'(corr_cnt),   0);
        chk({tag, "_uncorr"}, 32'(uncorr_cnt), 0);
        chk({tag, "_scrub"},  32'(scrub_cnt),  0);
        chk({tag, "_pass"},   32'(pass_cnt),   0);
        chk({tag, "_valid"},  32'(log_valid),  0);
        chk({tag, "_full"},   32'(log_full),   0);
        chk({tag, "_ovf"},    32'(overflow),   0);
        chk({tag, "_irq"},    32'(irq),        0);
        chk({tag, "_addr"},   32'(log_addr),   0);
        chk({tag, "_type"},   32'(log_uncorr), 0);
    endtask

    initial begin
        idle();
        err_addr = 8'h00;
        nGrst    = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        #4 nGrst = 1;
        #1;

        // single correctable
        ev(8'h12, 1, 0, 0);
        chk("c1_corr", 32'(corr_cnt), 1);
        chk("c1_unc", 32'(uncorr_cnt), 0);
        chk("c1_valid", 32'(log_valid), 1);
        chk("c1_addr", 32'(log_addr), 32'h12);
        chk("c1_type", 32'(log_uncorr), 0);
        chk("c1_irq", 32'(irq), 0);
        do_clr();
        chk("clr1_valid", 32'(log_valid), 0);
        chk("clr1_corr", 32'(corr_cnt), 0);

        // both flags -> uncorrectable only
        ev(8'h34, 1, 1, 0);
        chk("both_unc", 32'(uncorr_cnt), 1);
        chk("both_corr", 32'(corr_cnt), 0);
        chk("both_addr", 32'(log_addr), 32'h34);
        chk("both_type", 32'(log_uncorr), 1);
        chk("both_irq", 32'(irq), 1);
        pop = 1; tick(); idle();
        chk("both_single", 32'(log_valid), 0);
        do_clr();
        chk("clr2_irq", 32'(irq), 0);
        chk("clr2_unc", 32'(uncorr_cnt), 0);

        // overflow: five events into depth 4
        for (int i = 1; i <= 5; i++) ev(8'(i), 1, 0, 0);
        chk("ovf_full", 32'(log_full), 1);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_irq", 32'(irq), 1);
        chk("ovf_corr", 32'(corr_cnt), 5);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_pop_addr", 32'(log_addr), 32'(i));
            pop = 1; tick(); idle();
        end
        chk("ovf_drained", 32'(log_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // pop on empty is ignored
        pop = 1; tick(); idle();
        chk("pop_empty", 32'(log_valid), 0);
        ev(8'h30, 0, 1, 0);
        chk("after_pe_addr", 32'(log_addr), 32'h30);
        pop = 1; tick(); idle();

        // push + pop on full
        do_clr();
        for (int i = 1; i <= 4; i++) ev(8'h20 + 8'(i), 1, 0, 0);
        chk("pp_full", 32'(log_full), 1);
        chk("pp_ovf0", 32'(overflow), 0);
        ev(8'h25, 1, 0, 1);
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_full2", 32'(log_full), 1);
        chk("pp_head", 32'(log_addr), 32'h22);
        for (int i = 2; i <= 5; i++) begin
            chk("pp_seq", 32'(log_addr), 32'h20 + 32'(i));
            pop = 1; tick(); idle();
        end
        chk("pp_empty", 32'(log_valid), 0);

        // irq threshold at 8
        do_clr();
        for (int i = 0; i < 7; i++) ev(8'h40 + 8'(i), 1, 0, 1);
        chk("th7_corr", 32'(corr_cnt), 7);
        chk("th7_irq", 32'(irq), 0);
        chk("th7_ovf", 32'(overflow), 0);
        ev(8'h47, 1, 0, 1);
        chk("th8_corr", 32'(corr_cnt), 8);
        chk("th8_irq", 32'(irq), 1);
        clr = 1; ev(8'h55, 1, 0, 1);
        chk("clrev_corr", 32'(corr_cnt), 1);
        chk("clrev_valid", 32'(log_valid), 1);
        chk("clrev_addr", 32'(log_addr), 32'h55);
        chk("clrev_full", 32'(log_full), 0);
        chk("clrev_ovf", 32'(overflow), 0);
        chk("clrev_irq", 32'(irq), 0);

        // scrub saturation, with coincident uncorrectable events and pops
        scrub_corr = 1; scrub_done = 1; error = 1; pop = 1; err_addr = 8'h66;
        repeat (20) tick();
        idle();
        chk("scr4_cnt", 32'(scrub_cnt4), 15);
        chk("scr4_pass", 32'(pass_cnt4), 15);
        chk("scr4_unc", 32'(uncorr_cnt4), 15);
        chk("scr4_corr", 32'(corr_cnt4), 1);
        chk("scr_cnt", 32'(scrub_cnt), 20);
        chk("scr_pass", 32'(pass_cnt), 20);
        chk("scr_unc", 32'(uncorr_cnt), 20);
        chk("scr_ovf", 32'(overflow), 0);
        chk("scr_head", 32'(log_addr), 32'h66);
        chk("scr_type", 32'(log_uncorr), 1);

        // async reset mid-burst with FIFO half full
        ev(8'h67, 1, 0, 0);
        chk("mid_not_empty", 32'(log_valid), 1);
        correctable = 1; err_addr = 8'h77;
        #2 nGrst = 0;
        #1;
        chk_reset("async");
        #2 nGrst = 1;
        tick();
        idle();
        chk("post_corr", 32'(corr_cnt), 1);
        chk("post_addr", 32'(log_addr), 32'h77);
        chk("post_valid", 32'(log_valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
